// File: rtl/deferred_step_batcher_if.sv
// Batch handshake between deferred_step_batcher (master) and the host-side step consumer (slave).
interface deferred_step_batcher_if #(
  parameter int NUM_CORES = 1,
  parameter int ACC_WIDTH = 16
);
  logic                           flush_valid;
  logic                           flush_ready;
  logic [NUM_CORES*ACC_WIDTH-1:0] flush_step;

  modport master (output flush_valid, output flush_step, input flush_ready);
  modport slave  (input flush_valid, input flush_step, output flush_ready);
endinterface

// File: rtl/deferred_step_batcher.sv
// Accumulates per-core commit steps and releases them in batches; latches the sticky sim result.
// Optional idle-timeout flush is enabled by defining DEFERRED_STEP_TIMEOUT_EN.
module deferred_step_batcher #(
  parameter int NUM_CORES  = 1,
  parameter int STEP_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int THRESHOLD  = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_CORES*STEP_WIDTH-1:0] step,
  input  logic                            result_we,
  input  logic [7:0]                      result_in,
  deferred_step_batcher_if.master         flush_if,
  output logic [7:0]                      simv_result,
  output logic                            halted
);

  typedef enum logic [1:0] {ACCUM, FLUSH, HALT} state_t;

  localparam logic [ACC_WIDTH-1:0] THR = ACC_WIDTH'(THRESHOLD);

  if (ACC_WIDTH < STEP_WIDTH || THRESHOLD < 1 || TIMEOUT < 2) begin : g_cfg_check
    $error("deferred_step_batcher: invalid parameter combination");
  end

  state_t                              state_q, state_d;
  logic [NUM_CORES-1:0][ACC_WIDTH-1:0] acc_q, acc_d, next_acc, batch_q, batch_d;
  logic [NUM_CORES-1:0]                thr_hit, nz;
  logic                                valid_q, valid_d, halted_q, halted_d;
  logic [7:0]                          res_q, simv_q;
  logic                                res_set, any_nz, acc_zero, trigger, drain_done;
  logic                                timeout_hit;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    logic [ACC_WIDTH:0] sum;
    assign sum         = {1'b0, acc_q[g]} + (ACC_WIDTH+1)'(step[g*STEP_WIDTH +: STEP_WIDTH]);
    assign next_acc[g] = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
    assign thr_hit[g]  = next_acc[g] >= THR;
    assign nz[g]       = |next_acc[g];
  end

  assign res_set    = |res_q;
  assign any_nz     = |nz;
  assign acc_zero   = ~|acc_q;
  // res here is the pre-edge value, so a result write that lands with a crossing flushes first.
  assign trigger    = (|thr_hit) || timeout_hit || (res_set && any_nz);
  assign drain_done = res_set && !any_nz;

`ifdef DEFERRED_STEP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_q, timer_d;

  assign timeout_hit = (state_q == ACCUM) && (timer_q == TMAX);

  always_comb begin
    timer_d = '0;
    if (state_q == ACCUM && !trigger && !acc_zero) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    batch_d  = batch_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      ACCUM: begin
        if (trigger) begin
          batch_d = next_acc;
          acc_d   = '0;
          valid_d = 1'b1;
          state_d = FLUSH;
        end else if (drain_done) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          acc_d = next_acc;
        end
      end
      FLUSH: begin
        // Steps keep landing in acc while the batch is held; no re-trigger until accept.
        acc_d = next_acc;
        if (flush_if.flush_ready) begin
          if (trigger) begin
            batch_d = next_acc;
            acc_d   = '0;
          end else if (drain_done) begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            valid_d = 1'b0;
            state_d = ACCUM;
          end
        end
      end
      HALT: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      batch_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      res_q    <= '0;
      simv_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      batch_q  <= batch_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      simv_q   <= res_q;
      if (result_we && !res_set) begin
        res_q <= result_in;
      end
    end
  end

  assign flush_if.flush_valid = valid_q;
  assign flush_if.flush_step  = batch_q;
  assign simv_result          = simv_q;
  assign halted               = halted_q;

endmodule
